vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised, synthesizable VGA-style raster timing generator with a built-in test-pattern source. It produces hsync/vsync/data-enable, active-area pixel coordinates and frame/line strobes from a single pixel clock. It also drives 8-bit-per-channel (default) RGB from one of four selectable patterns. It sits at the head of the video path and feeds the simulator display model or downstream pixel logic.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync asserted level (0 = active-low)
- V_SYNC_POL, 0, vsync asserted level
- CW, 8, colour channel width
- CNT_W, 16, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  pixel clock
- rst  in  1  reset; **synchronous, active-high**
- en  in  1  pixel enable; counters advance only when high
- mode  in  2  pattern select: 0 gradient, 1 colour bars, 2 checkerboard, 3 solid
- solid_rgb  in  3*CW  solid colour {r,g,b} for mode 3
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  active-video enable
- x  out  CNT_W  active-area column; 0 when de=0
- y  out  CNT_W  active-area row; 0 when de=0
- r, g, b  out  CW each  pixel colour; 0 when de=0
- line_start  out  1  one-cycle strobe at hcnt=0
- frame_start  out  1  one-cycle strobe at hcnt=0, vcnt=0

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800 default). V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (525 default).
- Line/frame order is sync, back porch, active, front porch. Counter value 0 is the first sync pixel/line.
- hcnt wraps H_TOTAL-1→0. On that wrap, vcnt increments, and wraps V_TOTAL-1→0.
- Sync: hsync is at the asserted level while hcnt < H_SYNC, otherwise at the inverse. vsync follows the same rule using vcnt and V_SYNC.
- de = (H_SYNC+H_BP ≤ hcnt < H_SYNC+H_BP+H_ACTIVE) AND (V_SYNC+V_BP ≤ vcnt < V_SYNC+V_BP+V_ACTIVE).
- x = hcnt−(H_SYNC+H_BP) and y = vcnt−(V_SYNC+V_BP) when de; both 0 otherwise.
- Mode and solid colour are shadowed:
  - active_mode and active_solid load from mode/solid_rgb only on the en cycle where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1.
  - On rst they load directly from the inputs.
  - A mid-frame change of mode never tears a frame.
- Patterns (evaluated from x, y):
  - 0 gradient: r=g=x[CW-1:0], b=0.
  - 1 colour bars: BAR_W = H_ACTIVE/8 (floor); bar k covers x ∈ [k·BAR_W,(k+1)·BAR_W). Columns ≥ 7·BAR_W belong to bar 7. Colours in order: white, yellow, cyan, green, magenta, red, blue, black, with full-scale = all ones. Bar select uses constant comparisons, no divider.
  - 2 checkerboard: white if x[4]^y[4], else black (16×16 squares).
  - 3 solid: {r,g,b} = active_solid.
- en=0: counters and all level outputs hold. line_start and frame_start are forced to 0.
- rst (any cycle, mid-frame included):
  - hcnt=vcnt=0.
  - hsync/vsync at the deasserted level.
  - de=0, x=y=0, r=g=b=0, line_start=frame_start=0.

## Timing
- All outputs are registered and mutually aligned, with 1 cycle of latency from the counter state.
- The output on the cycle after an en cycle reflects the pre-increment counter values.
- First en cycle after rst release: the following outputs show hcnt=0, vcnt=0 — hsync and vsync asserted, line_start=frame_start=1, de=0.
- With en held high:
  - Period between line_start pulses: H_TOTAL cycles.
  - Period between frame_start pulses: H_TOTAL·V_TOTAL cycles.
  - Each en=0 cycle stretches these by exactly one cycle.
- The new pattern appears on the first active pixel after the frame_start that follows the mode change.

## Test plan
- Reset: assert rst for 3 cycles mid-line → outputs hsync=vsync=1 (default polarity), de=0, r=g=b=0, strobes 0. The first en cycle after release gives frame_start=1 and hsync=0.
- Line timing (defaults, en=1):
  - hsync low for exactly 96 consecutive cycles and line_start every 800 cycles.
  - de high for 640 cycles starting 144 cycles after line_start, x counting 0..639.
- Frame timing: frame_start spacing = 420000 cycles. vsync low for 1600 cycles. de asserted on exactly 480 lines, with y 0..479.
- Colour bars (mode=1): x=0 → (FF,FF,FF); x=80 → (FF,FF,00); x=400 → (FF,00,00); x=639 → (00,00,00). Every blanking cycle → (00,00,00).
- Shadowed mode: switch mode 0→3 with solid_rgb=0x123456 at line 200 → remainder of the frame stays gradient. After the next frame_start every active pixel = (12,34,56).
- Enable/polarity:
  - Hold en=0 for 5 cycles mid-line → outputs frozen, no strobes, line period measured as 805.
  - Rerun with H_SYNC_POL=1, V_SYNC_POL=1 → sync outputs inverted, de unchanged.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator and its consumer.
// master is the generator side; slave is the display or pixel-logic side.
interface vga_timing_gen_if #(
    parameter int CW    = 8,
    parameter int CNT_W = 16
);
    logic              en;
    logic [1:0]        mode;
    logic [3*CW-1:0]   solid_rgb;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [CW-1:0]     r;
    logic [CW-1:0]     g;
    logic [CW-1:0]     b;
    logic              line_start;
    logic              frame_start;

    modport master (
        input  en, mode, solid_rgb,
        output hsync, vsync, de, x, y, r, g, b, line_start, frame_start
    );

    modport slave (
        output en, mode, solid_rgb,
        input  hsync, vsync, de, x, y, r, g, b, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator with a built-in four-way test-pattern source.
// Every output is registered one cycle after the counter state it describes.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CW         = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vid
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

    localparam logic HS_ON = (H_SYNC_POL != 0);
    localparam logic VS_ON = (V_SYNC_POL != 0);

    // Left edges of bars 1..7; anything past the last edge stays in bar 7.
    localparam logic [CNT_W-1:0] BAR_E1 = CNT_W'(1 * BAR_W);
    localparam logic [CNT_W-1:0] BAR_E2 = CNT_W'(2 * BAR_W);
    localparam logic [CNT_W-1:0] BAR_E3 = CNT_W'(3 * BAR_W);
    localparam logic [CNT_W-1:0] BAR_E4 = CNT_W'(4 * BAR_W);
    localparam logic [CNT_W-1:0] BAR_E5 = CNT_W'(5 * BAR_W);
    localparam logic [CNT_W-1:0] BAR_E6 = CNT_W'(6 * BAR_W);
    localparam logic [CNT_W-1:0] BAR_E7 = CNT_W'(7 * BAR_W);

    function automatic logic sync_level(input logic in_sync, input logic on_level);
        return in_sync ? on_level : ~on_level;
    endfunction

    // Returns {r_on, g_on, b_on} for the bar containing column col.
    function automatic logic [2:0] bar_colour(input logic [CNT_W-1:0] col);
        logic [2:0] c;
        if (col < BAR_E1)      c = 3'b111;
        else if (col < BAR_E2) c = 3'b110;
        else if (col < BAR_E3) c = 3'b011;
        else if (col < BAR_E4) c = 3'b010;
        else if (col < BAR_E5) c = 3'b101;
        else if (col < BAR_E6) c = 3'b100;
        else if (col < BAR_E7) c = 3'b001;
        else                   c = 3'b000;
        return c;
    endfunction

    function automatic logic [3*CW-1:0] expand(input logic [2:0] on);
        return {{CW{on[2]}}, {CW{on[1]}}, {CW{on[0]}}};
    endfunction

    function automatic logic [3*CW-1:0] pattern(
        input logic [1:0]       sel,
        input logic [CNT_W-1:0] col,
        input logic             row_b4,
        input logic [3*CW-1:0]  solid
    );
        logic [3*CW-1:0] px;
        case (sel)
            2'd0:    px = {col[CW-1:0], col[CW-1:0], {CW{1'b0}}};
            2'd1:    px = expand(bar_colour(col));
            2'd2:    px = {(3*CW){col[4] ^ row_b4}};
            default: px = solid;
        endcase
        return px;
    endfunction

    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [3*CW-1:0]  solid_q, solid_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [3*CW-1:0]  rgb_q, rgb_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;

    logic             h_wrap, v_wrap, h_act, v_act, act;
    logic [CNT_W-1:0] col, row;

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        v_wrap = (vcnt_q == V_LAST);
        h_act  = (hcnt_q >= H_ACT_BEG) && (hcnt_q < H_ACT_END);
        v_act  = (vcnt_q >= V_ACT_BEG) && (vcnt_q < V_ACT_END);
        act    = h_act && v_act;
        col    = hcnt_q - H_ACT_BEG;
        row    = vcnt_q - V_ACT_BEG;

        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        mode_d  = mode_q;
        solid_d = solid_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        x_d     = x_q;
        y_d     = y_q;
        rgb_d   = rgb_q;
        line_d  = 1'b0;
        frame_d = 1'b0;

        if (vid.en) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + CNT_W'(1);
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + CNT_W'(1);
            end
            // Pattern selection only changes across the frame boundary.
            if (h_wrap && v_wrap) begin
                mode_d  = vid.mode;
                solid_d = vid.solid_rgb;
            end

            hsync_d = sync_level(hcnt_q < H_SYNC_END, HS_ON);
            vsync_d = sync_level(vcnt_q < V_SYNC_END, VS_ON);
            de_d    = act;
            x_d     = act ? col : '0;
            y_d     = act ? row : '0;
            rgb_d   = act ? pattern(mode_q, col, row[4], solid_q) : '0;
            line_d  = (hcnt_q == '0);
            frame_d = (hcnt_q == '0) && (vcnt_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            mode_q  <= vid.mode;
            solid_q <= vid.solid_rgb;
            hsync_q <= ~HS_ON;
            vsync_q <= ~VS_ON;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rgb_q   <= '0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            rgb_q   <= rgb_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.r           = rgb_q[3*CW-1:2*CW];
    assign vid.g           = rgb_q[2*CW-1:CW];
    assign vid.b           = rgb_q[CW-1:0];
    assign vid.line_start  = line_q;
    assign vid.frame_start = frame_q;
endmodule
